iwdg_mc: RTL and testbench
==========================

IWDG_MC -- requirements
Module: iwdg_mc

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent watchdog channels (1..8).
REQ-002 SHALL have parameter RLR_SIZE, default 12, reload/window counter width.
REQ-003 SHALL have parameter PR_SIZE, default 3, prescaler select width.
REQ-004 SHALL have parameter DAT_SIZE, default 16, bus data width.
REQ-005 SHALL have parameter RST_PULSE, default 4, clk cycles iwdg_rst held per timeout.
REQ-006 SHALL have parameter BASE_ADR, default 32'h0100_0000, register base; channel c at BASE_ADR + 32*c.
REQ-007 clk  in  1  single clock for bus and counters.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 dat_m2s  in  DAT_SIZE  write data; adr_m2s  in  32  byte address.
REQ-010 cyc_m2s, stb_m2s, we_m2s  in  1 each  Wishbone cycle, strobe, write-enable.
REQ-011 dat_s2m  out  DAT_SIZE  read data; ack_s2m  out  1  transfer acknowledge.
REQ-012 iwdg_rst  out  N_CH  per-channel timeout reset; iwdg_rst_any  out  1  OR of iwdg_rst.

Function
REQ-013 Per-channel offsets SHALL be KR 0x00 (W), PR 0x04, RLR 0x08, SR 0x0C (R, W1C), WINR 0x10.
REQ-014 ack_s2m SHALL pulse one cycle, the cycle after cyc&stb sampled high with ack low; back-to-back requests ack every other cycle.
REQ-015 Writes SHALL take effect on the ack cycle; unmapped address SHALL ack, read 0, write ignored.
REQ-016 KR keys: 0xCCCC start, 0xAAAA reload, 0x5555 unlock; any other KR write relocks; KR reads 0.
REQ-017 PR/RLR/WINR writes SHALL apply only when unlocked; locked writes acked, dropped; PR/RLR/WINR always readable, zero-extended.
REQ-018 Channel FSM states IDLE, RUN, FIRE; IDLE->RUN on 0xCCCC (counter loaded with RLR); RUN->FIRE when counter decrements from 0 or on early reload; FIRE->IDLE after RST_PULSE cycles.
REQ-019 In RUN, 0xCCCC SHALL be ignored; no software stop; 0xAAAA in IDLE SHALL load counter only.
REQ-020 Prescaler tick every 4<<PR cycles (PR 0..6); PR=7 SHALL equal PR=6 (256); prescaler clears on start and reload.
REQ-021 Counter decrements one per tick in RUN only; it does not wrap.
REQ-022 Window: 0xAAAA while counter > WINR SHALL be early reload -> FIRE, SR.EWF set; WINR = all-ones disables window.
REQ-023 New PR/RLR written while running SHALL be used from the next reload/start.
REQ-024 Reload in the same cycle the counter would expire SHALL win (no FIRE).
REQ-025 iwdg_rst[c] SHALL be high exactly during FIRE; SR.TOF set on entering FIRE via expiry.
REQ-026 SR bits: [0] RUN, [1] unlocked, [2] TOF, [3] EWF; TOF/EWF sticky, cleared by writing 1; others 0.
REQ-027 Channels SHALL be fully independent; one bus access touches one channel.

Reset
REQ-028 rst SHALL immediately force: ack_s2m 0, dat_s2m 0, iwdg_rst 0, all channels IDLE, locked.
REQ-029 Reset values: PR 0, RLR all-ones, WINR all-ones, counter all-ones, prescaler 0, SR 0.
REQ-030 rst mid-FIRE SHALL truncate the pulse; mid-transfer SHALL drop the pending ack.

Structure
REQ-031 Package iwdg_mc_pkg SHALL hold key constants, register offsets, SR bit indices, channel state enum.
REQ-032 Sub-module iwdg_mc_ch SHALL implement one channel (FSM, prescaler, counter, regs); top does address decode, ack, read mux, generate over N_CH.

Verification
REQ-033 rst 10 cycles, read ch0 RLR -> 0x0FFF; read SR -> 0x0000; iwdg_rst 0.
REQ-034 ch1: 0x5555, RLR=0x002, PR=0, 0xCCCC -> iwdg_rst[1] high 4 cycles starting ~12 cycles after start, SR=0x0004, other bits of iwdg_rst 0.
REQ-035 ch0: unlock, RLR=0x010, WINR=0x008, start, 0xAAAA at counter 0x00C -> FIRE, SR.EWF=1; repeat at counter 0x005 -> counter reloads 0x010, no FIRE.
REQ-036 Locked write RLR=0x001 -> acked, RLR reads 0x0FFF; write SR 0x0004 after timeout -> TOF cleared.
REQ-037 Reload issued on exact expiry cycle -> no iwdg_rst; rst asserted during FIRE -> iwdg_rst drops same time step.

Source files
------------

// File: rtl/iwdg_mc_pkg.sv
// Shared constants for the multi-channel independent watchdog: keys, register
// offsets, status bit positions and the channel state encoding.
package iwdg_mc_pkg;

  localparam logic [15:0] KEY_START  = 16'hCCCC;
  localparam logic [15:0] KEY_RELOAD = 16'hAAAA;
  localparam logic [15:0] KEY_UNLOCK = 16'h5555;

  localparam logic [4:0] OFF_KR   = 5'h00;
  localparam logic [4:0] OFF_PR   = 5'h04;
  localparam logic [4:0] OFF_RLR  = 5'h08;
  localparam logic [4:0] OFF_SR   = 5'h0C;
  localparam logic [4:0] OFF_WINR = 5'h10;

  localparam int SR_RUN = 0;
  localparam int SR_UNL = 1;
  localparam int SR_TOF = 2;
  localparam int SR_EWF = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIRE = 2'd2
  } ch_state_t;

  // Last prescaler count before a tick: period is 4 << pr, saturating at pr = 6.
  function automatic logic [7:0] presc_last(input logic [31:0] pr);
    logic [31:0] p;
    p = (pr > 32'd6) ? 32'd6 : pr;
    return 8'((32'd4 << p) - 32'd1);
  endfunction

endpackage

// File: rtl/iwdg_mc_ch.sv
// One watchdog channel: key/lock handling, PR/RLR/WINR/SR registers,
// prescaler, down-counter and the IDLE/RUN/FIRE state machine.
module iwdg_mc_ch
  import iwdg_mc_pkg::*;
#(
  parameter int RLR_SIZE  = 12,
  parameter int PR_SIZE   = 3,
  parameter int DAT_SIZE  = 16,
  parameter int RST_PULSE = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [4:0]          off,
  input  logic [DAT_SIZE-1:0] wdat,
  output logic [DAT_SIZE-1:0] rdat,
  output logic [1:0]          state_dbg
);

  localparam int FC_W = $clog2(RST_PULSE + 1);

  ch_state_t           state;
  logic                unl, tof, ewf;
  logic [PR_SIZE-1:0]  pr, pr_act;
  logic [RLR_SIZE-1:0] rlr, winr, cnt;
  logic [7:0]          presc;
  logic [FC_W-1:0]     fire_cnt;

  logic wr_kr, key_start, key_reload, tick, win_on;

  assign wr_kr      = wr_en && (off == OFF_KR);
  assign key_start  = wr_kr && (wdat == DAT_SIZE'(KEY_START));
  assign key_reload = wr_kr && (wdat == DAT_SIZE'(KEY_RELOAD));
  assign tick       = (presc == presc_last(32'(pr_act)));
  assign win_on     = (winr != {RLR_SIZE{1'b1}});
  assign state_dbg  = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      unl      <= 1'b0;
      tof      <= 1'b0;
      ewf      <= 1'b0;
      pr       <= '0;
      pr_act   <= '0;
      rlr      <= '1;
      winr     <= '1;
      cnt      <= '1;
      presc    <= '0;
      fire_cnt <= '0;
    end else begin
      if (wr_kr) unl <= (wdat == DAT_SIZE'(KEY_UNLOCK));
      if (wr_en && unl && off == OFF_PR)   pr   <= wdat[PR_SIZE-1:0];
      if (wr_en && unl && off == OFF_RLR)  rlr  <= wdat[RLR_SIZE-1:0];
      if (wr_en && unl && off == OFF_WINR) winr <= wdat[RLR_SIZE-1:0];
      if (wr_en && off == OFF_SR) begin
        if (wdat[SR_TOF]) tof <= 1'b0;
        if (wdat[SR_EWF]) ewf <= 1'b0;
      end
      // Flag sets below come after the W1C clears so a coincident event wins.
      case (state)
        ST_IDLE: begin
          presc <= '0;
          if (key_start) begin
            state  <= ST_RUN;
            cnt    <= rlr;
            pr_act <= pr;
          end else if (key_reload) begin
            cnt <= rlr;
          end
        end
        ST_RUN: begin
          if (key_reload) begin
            if (win_on && cnt > winr) begin
              state    <= ST_FIRE;
              fire_cnt <= '0;
              ewf      <= 1'b1;
            end else begin
              cnt    <= rlr;
              pr_act <= pr;
              presc  <= '0;
            end
          end else if (tick) begin
            presc <= '0;
            if (cnt == '0) begin
              state    <= ST_FIRE;
              fire_cnt <= '0;
              tof      <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end else begin
            presc <= presc + 8'd1;
          end
        end
        ST_FIRE: begin
          if (fire_cnt == FC_W'(RST_PULSE - 1)) state <= ST_IDLE;
          else fire_cnt <= fire_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rdat = '0;
    case (off)
      OFF_PR:   rdat = DAT_SIZE'(pr);
      OFF_RLR:  rdat = DAT_SIZE'(rlr);
      OFF_WINR: rdat = DAT_SIZE'(winr);
      OFF_SR: begin
        rdat[SR_RUN] = (state == ST_RUN);
        rdat[SR_UNL] = unl;
        rdat[SR_TOF] = tof;
        rdat[SR_EWF] = ewf;
      end
      default: rdat = '0;
    endcase
  end

endmodule

// File: rtl/iwdg_mc.sv
// Multi-channel watchdog top: Wishbone slave with address decode, single-cycle
// ack, read mux, and one iwdg_mc_ch per channel.
module iwdg_mc
  import iwdg_mc_pkg::*;
#(
  parameter int          N_CH      = 4,
  parameter int          RLR_SIZE  = 12,
  parameter int          PR_SIZE   = 3,
  parameter int          DAT_SIZE  = 16,
  parameter int          RST_PULSE = 4,
  parameter logic [31:0] BASE_ADR  = 32'h0100_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DAT_SIZE-1:0] dat_m2s,
  input  logic [31:0]         adr_m2s,
  input  logic                cyc_m2s,
  input  logic                stb_m2s,
  input  logic                we_m2s,
  output logic [DAT_SIZE-1:0] dat_s2m,
  output logic                ack_s2m,
  output logic [N_CH-1:0]     iwdg_rst,
  output logic                iwdg_rst_any
);

  // Handshake: a request is cyc&stb sampled high while ack is low; ack follows
  // one cycle later for exactly one cycle, and writes land on that same edge.
  logic [31:0]         rel;
  logic [26:0]         ch_idx;
  logic [4:0]          off;
  logic                req, hit;
  logic [DAT_SIZE-1:0] rd_mux;
  logic [DAT_SIZE-1:0] rd_dat   [N_CH];
  logic [1:0]          ch_state [N_CH];

  assign rel    = adr_m2s - BASE_ADR;
  assign ch_idx = rel[31:5];
  assign off    = rel[4:0];
  assign req    = cyc_m2s & stb_m2s & ~ack_s2m;
  assign hit    = (ch_idx < 27'(N_CH));

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic wr_en;
    assign wr_en = req & we_m2s & hit & (ch_idx == 27'(c));

    iwdg_mc_ch #(
      .RLR_SIZE (RLR_SIZE),
      .PR_SIZE  (PR_SIZE),
      .DAT_SIZE (DAT_SIZE),
      .RST_PULSE(RST_PULSE)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .off      (off),
      .wdat     (dat_m2s),
      .rdat     (rd_dat[c]),
      .state_dbg(ch_state[c])
    );

    assign iwdg_rst[c] = (ch_state[c] == ST_FIRE);
  end

  assign iwdg_rst_any = |iwdg_rst;

  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (hit && ch_idx == 27'(c)) rd_mux = rd_dat[c];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_s2m <= 1'b0;
      dat_s2m <= '0;
    end else begin
      ack_s2m <= req;
      dat_s2m <= (req && !we_m2s) ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_iwdg_mc.sv
// Directed bench for iwdg_mc with a deadline-based channel model and a
// per-cycle compare of the watchdog reset outputs.
module tb_iwdg_mc;

  localparam int          NC   = 4;
  localparam int          RP   = 4;
  localparam logic [31:0] BASE = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] dat_m2s = '0;
  logic [31:0] adr_m2s = '0;
  logic        cyc_m2s = 1'b0, stb_m2s = 1'b0, we_m2s = 1'b0;
  logic [15:0] dat_s2m;
  logic        ack_s2m;
  logic [NC-1:0] iwdg_rst;
  logic        iwdg_rst_any;

  iwdg_mc dut (
    .clk(clk), .rst(rst), .dat_m2s(dat_m2s), .adr_m2s(adr_m2s),
    .cyc_m2s(cyc_m2s), .stb_m2s(stb_m2s), .we_m2s(we_m2s),
    .dat_s2m(dat_s2m), .ack_s2m(ack_s2m),
    .iwdg_rst(iwdg_rst), .iwdg_rst_any(iwdg_rst_any)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int  chk_cnt = 0, pass_cnt = 0;
  bit  chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Model: each channel is described by its last load edge, reload value and
  // prescaler period, from which the fire edge is a plain deadline.
  int m_fs[NC], m_k0[NC], m_r[NC], m_per[NC], m_pr[NC], m_rlr[NC], m_winr[NC];
  bit m_run[NC], m_exp[NC], m_tof[NC], m_ewf[NC], m_unl[NC];

  function automatic int per_of(input int pr);
    return 4 << ((pr > 6) ? 6 : pr);
  endfunction

  function automatic bit m_fire(input int c, input int e);
    return (e >= m_fs[c]) && (e < m_fs[c] + RP);
  endfunction

  function automatic bit m_running(input int c, input int e);
    return m_run[c] && (e < m_fs[c]);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_fs[c] = -1000; m_k0[c] = 0; m_r[c] = 0; m_per[c] = 4;
      m_pr[c] = 0; m_rlr[c] = 'hFFF; m_winr[c] = 'hFFF;
      m_run[c] = 0; m_exp[c] = 0; m_tof[c] = 0; m_ewf[c] = 0; m_unl[c] = 0;
    end
  endtask

  task automatic fold(input int c, input int e);
    if (m_exp[c] && m_fs[c] <= e) begin
      m_tof[c] = 1; m_exp[c] = 0;
    end
  endtask

  task automatic load(input int c, input int k);
    m_k0[c] = k; m_r[c] = m_rlr[c]; m_per[c] = per_of(m_pr[c]);
    m_fs[c] = k + m_per[c] * (m_r[c] + 1); m_exp[c] = 1;
  endtask

  task automatic model_write(input int c, input int off, input int d, input int k);
    bit run, idle;
    int cnt;
    fold(c, k - 1);
    run  = m_running(c, k - 1);
    idle = !run && !m_fire(c, k - 1);
    case (off)
      'h00: begin
        m_unl[c] = (d == 'h5555);
        if (d == 'hCCCC && idle) begin
          m_run[c] = 1; load(c, k);
        end
        if (d == 'hAAAA && run) begin
          cnt = m_r[c] - (k - 1 - m_k0[c]) / m_per[c];
          if (m_winr[c] != 'hFFF && cnt > m_winr[c]) begin
            m_fs[c] = k; m_exp[c] = 0; m_ewf[c] = 1;
          end else load(c, k);
        end
      end
      'h04: if (m_unl[c]) m_pr[c] = d & 'h7;
      'h08: if (m_unl[c]) m_rlr[c] = d & 'hFFF;
      'h10: if (m_unl[c]) m_winr[c] = d & 'hFFF;
      'h0C: begin
        if (d[2]) m_tof[c] = 0;
        if (d[3]) m_ewf[c] = 0;
      end
      default: ;
    endcase
  endtask

  task automatic model_read(input int c, input int off, input int k, output logic [15:0] v);
    v = '0;
    fold(c, k - 1);
    case (off)
      'h04: v = 16'(m_pr[c]);
      'h08: v = 16'(m_rlr[c]);
      'h10: v = 16'(m_winr[c]);
      'h0C: v = {12'd0, m_ewf[c], m_tof[c], m_unl[c], m_running(c, k - 1)};
      default: v = '0;
    endcase
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      logic [NC-1:0] e;
      for (int c = 0; c < NC; c++) e[c] = m_fire(c, edge_cnt);
      check("iwdg_rst", 32'(iwdg_rst), 32'(e));
      check("iwdg_rst_any", 32'(iwdg_rst_any), 32'(|e));
    end
  end

  // Bus transfer; called at a negedge, returns at the negedge after the ack drops.
  task automatic bus(input bit we, input logic [31:0] adr, input logic [15:0] wd,
                     output logic [15:0] rd, output int k);
    logic [31:0] rel;
    logic [15:0] ev;
    cyc_m2s = 1; stb_m2s = 1; we_m2s = we; adr_m2s = adr; dat_m2s = wd;
    @(posedge clk); #1;
    k  = edge_cnt;
    rd = dat_s2m;
    check("ack", 32'(ack_s2m), 32'd1);
    rel = adr - BASE;
    if (we) begin
      if ((rel >> 5) < NC) model_write(int'(rel >> 5), int'(rel[4:0]), int'(wd), k);
    end else begin
      if ((rel >> 5) < NC) model_read(int'(rel >> 5), int'(rel[4:0]), k, ev);
      else ev = '0;
      check("rd_model", 32'(rd), 32'(ev));
    end
    @(negedge clk);
    cyc_m2s = 0; stb_m2s = 0; we_m2s = 0;
    @(negedge clk);
  endtask

  function automatic logic [31:0] ra(input int c, input int off);
    return BASE + 32'(32 * c + off);
  endfunction

  task automatic wr(input int c, input int off, input int d, output int k);
    logic [15:0] rd;
    bus(1'b1, ra(c, off), 16'(d), rd, k);
  endtask

  task automatic rdr(input int c, input int off, output logic [15:0] v);
    int k;
    bus(1'b0, ra(c, off), 16'd0, v, k);
  endtask

  task automatic goto_edge(input int k);
    check("sched", 32'(edge_cnt <= k - 1), 32'd1);
    while (edge_cnt < k - 1) @(negedge clk);
  endtask

  task automatic measure(input int c, input int ref_e, input int n, output int rise, output int width);
    rise = -1; width = 0;
    repeat (n) begin
      @(negedge clk);
      if (iwdg_rst[c]) begin
        if (rise < 0) rise = edge_cnt - ref_e;
        width++;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] v;
    int k, k0, rise, width;
    model_reset();
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk_en = 1;
    check("reset_iwdg_rst", 32'(iwdg_rst), 32'd0);

    // Reset values and unmapped space
    rdr(0, 'h08, v); check("lit_rlr_reset", 32'(v), 32'h0FFF);
    rdr(0, 'h0C, v); check("lit_sr_reset", 32'(v), 32'h0000);
    rdr(0, 'h10, v); check("lit_winr_reset", 32'(v), 32'h0FFF);
    rdr(0, 'h00, v); check("lit_kr_read", 32'(v), 32'h0000);
    rdr(0, 'h14, v); check("lit_unmapped", 32'(v), 32'h0000);
    rdr(4, 'h08, v); check("lit_no_channel", 32'(v), 32'h0000);

    // Channel 1 timeout with RLR=2, PR=0
    wr(1, 'h00, 'h5555, k);
    wr(1, 'h08, 'h0002, k);
    wr(1, 'h04, 'h0000, k);
    wr(1, 'h00, 'hCCCC, k0);
    measure(1, k0, 25, rise, width);
    check("lit_tmo_rise", 32'(rise), 32'd12);
    check("lit_tmo_width", 32'(width), 32'd4);
    rdr(1, 'h0C, v); check("lit_sr_tof", 32'(v), 32'h0004);
    wr(1, 'h0C, 'h0004, k);
    rdr(1, 'h0C, v); check("lit_sr_cleared", 32'(v), 32'h0000);

    // Channel 0 window: early reload fires, in-window reload restarts
    wr(0, 'h00, 'h5555, k);
    wr(0, 'h08, 'h0010, k);
    wr(0, 'h10, 'h0008, k);
    wr(0, 'h00, 'hCCCC, k0);
    goto_edge(k0 + 18);
    wr(0, 'h00, 'hAAAA, k);
    check("lit_early_fire", 32'(iwdg_rst[0]), 32'd1);
    repeat (6) @(negedge clk);
    rdr(0, 'h0C, v); check("lit_sr_ewf", 32'(v), 32'h0008);
    wr(0, 'h00, 'hCCCC, k0);
    goto_edge(k0 + 46);
    wr(0, 'h00, 'hAAAA, k);
    measure(0, k, 75, rise, width);
    check("lit_win_reload_rise", 32'(rise), 32'd68);
    check("lit_win_reload_width", 32'(width), 32'd4);

    // Channel 2 lock behaviour
    wr(2, 'h00, 'h5555, k);
    wr(2, 'h04, 'h0005, k);
    rdr(2, 'h04, v); check("lit_pr_unlocked", 32'(v), 32'h0005);
    wr(2, 'h00, 'h1234, k);
    wr(2, 'h08, 'h0001, k);
    rdr(2, 'h08, v); check("lit_rlr_locked", 32'(v), 32'h0FFF);
    rdr(2, 'h0C, v); check("lit_sr_locked", 32'(v), 32'h0000);

    // Channel 3: reload on the expiry edge, then reset during FIRE
    wr(3, 'h00, 'h5555, k);
    wr(3, 'h08, 'h0001, k);
    wr(3, 'h04, 'h0000, k);
    wr(3, 'h00, 'hCCCC, k0);
    goto_edge(k0 + 8);
    wr(3, 'h00, 'hAAAA, k);
    check("lit_exact_reload_quiet", 32'(iwdg_rst[3]), 32'd0);
    for (int i = 0; i < 20 && !iwdg_rst[3]; i++) @(negedge clk);
    check("lit_exact_reload_rise", 32'(edge_cnt - k), 32'd8);
    #2 rst = 1;
    model_reset();
    #1;
    check("lit_rst_drop", 32'(iwdg_rst), 32'd0);
    check("lit_rst_drop_any", 32'(iwdg_rst_any), 32'd0);
    check("lit_rst_ack", 32'(ack_s2m), 32'd0);
    repeat (3) @(negedge clk);
    rst = 0;
    rdr(3, 'h0C, v); check("lit_sr_after_rst", 32'(v), 32'h0000);
    rdr(3, 'h08, v); check("lit_rlr_after_rst", 32'(v), 32'h0FFF);
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
